// File: rtl/bomb_scheduler.sv
// bomb_scheduler: shared bomb-slot pool for two players. Arbitrates drop
// requests, snaps bombs to the tile grid and runs per-slot fuse/blast timers.
// Optional build macro: CHAIN_REACT_EN (a blast detonates nearby fused bombs).
module bomb_scheduler #(
   parameter int unsigned NUM_SLOTS      = 4,
   parameter int unsigned MAX_PER_PLAYER = 2,
   parameter int unsigned FUSE_FRAMES    = 120,
   parameter int unsigned BLAST_FRAMES   = 30,
   parameter int unsigned TILE_LOG2      = 4
) (
   input  logic                      frame_clk,
   input  logic                      Reset,
   input  logic                      p1_drop,
   input  logic [9:0]                p1_x,
   input  logic [9:0]                p1_y,
   input  logic                      p2_drop,
   input  logic [9:0]                p2_x,
   input  logic [9:0]                p2_y,
   output logic                      p1_ack,
   output logic                      p2_ack,
   output logic [NUM_SLOTS-1:0]      slot_fuse,
   output logic [NUM_SLOTS-1:0]      slot_blast,
   output logic [NUM_SLOTS-1:0]      slot_owner,
   output logic [10*NUM_SLOTS-1:0]   bomb_x,
   output logic [10*NUM_SLOTS-1:0]   bomb_y,
   output logic [NUM_SLOTS-1:0]      explode
);

   localparam int unsigned TMAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
   localparam int unsigned TW   = $clog2(TMAX);
   localparam int unsigned CW   = $clog2(NUM_SLOTS + 1);
   localparam int unsigned SW   = $clog2(NUM_SLOTS);
   localparam int unsigned TXW  = 10 - TILE_LOG2;
   localparam logic [9:0]  HALF = 10'(1 << (TILE_LOG2 - 1));

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FUSE = 2'd1, S_BLAST = 2'd2} state_t;

   state_t            r_state     [NUM_SLOTS];
   state_t            w_state_nxt [NUM_SLOTS];
   logic [TW-1:0]     r_timer     [NUM_SLOTS];
   logic [TW-1:0]     w_timer_nxt [NUM_SLOTS];
   logic [9:0]        r_bx        [NUM_SLOTS];
   logic [9:0]        r_by        [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] r_owner;
   logic [NUM_SLOTS-1:0] r_explode;
   logic [NUM_SLOTS-1:0] w_expl_nxt;
   logic [NUM_SLOTS-1:0] w_chain;

   logic r_p1_prev, r_p2_prev, r_p1_pend, r_p2_pend, r_rr_p2, r_p1_ack, r_p2_ack;
   logic w_req1, w_req2, w_sel_any, w_sel_p2, w_free, w_conflict, w_grant;
   logic [9:0]    w_sel_x, w_sel_y, w_bx, w_by;
   logic [SW-1:0] w_free_idx;
   logic [CW-1:0] w_cnt;

   // Request detection, arbitration select and tile snap of the selected player
   always_comb begin
      w_req1    = r_p1_pend | (p1_drop & ~r_p1_prev);
      w_req2    = r_p2_pend | (p2_drop & ~r_p2_prev);
      w_sel_any = w_req1 | w_req2;
      w_sel_p2  = w_req2 & (~w_req1 | r_rr_p2);
      w_sel_x   = w_sel_p2 ? p2_x : p1_x;
      w_sel_y   = w_sel_p2 ? p2_y : p1_y;
      w_bx      = {w_sel_x[9:TILE_LOG2], {TILE_LOG2{1'b0}}} | HALF;
      w_by      = {w_sel_y[9:TILE_LOG2], {TILE_LOG2{1'b0}}} | HALF;
   end

   // Grant qualification: free slot (lowest index), tile conflict, per-player quota
   always_comb begin
      w_free     = 1'b0;
      w_free_idx = '0;
      w_conflict = 1'b0;
      w_cnt      = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (r_state[i] == S_IDLE) begin
            w_free     = 1'b1;
            w_free_idx = SW'(i);
         end else if (r_owner[i] == w_sel_p2) begin
            w_cnt = w_cnt + CW'(1);
         end
         if (r_state[i] == S_FUSE && r_bx[i] == w_bx && r_by[i] == w_by)
            w_conflict = 1'b1;
      end
      w_grant = w_sel_any & w_free & ~w_conflict & (w_cnt < CW'(MAX_PER_PLAYER));
   end

`ifdef CHAIN_REACT_EN
   function automatic logic near2(input logic [TXW-1:0] a, input logic [TXW-1:0] b);
      return ((a > b) ? (a - b) : (b - a)) <= TXW'(2);
   endfunction

   // Fused bombs in line with an active blast, within two tiles, detonate early
   always_comb begin
      w_chain = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         for (int j = 0; j < NUM_SLOTS; j++) begin
            if (r_state[i] == S_FUSE && r_state[j] == S_BLAST) begin
               if ((r_by[i][9:TILE_LOG2] == r_by[j][9:TILE_LOG2] &&
                    near2(r_bx[i][9:TILE_LOG2], r_bx[j][9:TILE_LOG2])) ||
                   (r_bx[i][9:TILE_LOG2] == r_bx[j][9:TILE_LOG2] &&
                    near2(r_by[i][9:TILE_LOG2], r_by[j][9:TILE_LOG2])))
                  w_chain[i] = 1'b1;
            end
         end
      end
   end
`else
   assign w_chain = '0;
`endif

   // Slot state register
   always_ff @(posedge frame_clk) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (Reset) r_state[i] <= S_IDLE;
         else       r_state[i] <= w_state_nxt[i];
      end
   end

   // Slot next state with timer reload/decrement and detonation pulse
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         w_state_nxt[i] = r_state[i];
         w_timer_nxt[i] = r_timer[i];
         w_expl_nxt[i]  = 1'b0;
         case (r_state[i])
            S_IDLE: begin
               if (w_grant && w_free_idx == SW'(i)) begin
                  w_state_nxt[i] = S_FUSE;
                  w_timer_nxt[i] = TW'(FUSE_FRAMES - 1);
               end
            end
            S_FUSE: begin
               if (r_timer[i] == '0 || w_chain[i]) begin
                  w_state_nxt[i] = S_BLAST;
                  w_timer_nxt[i] = TW'(BLAST_FRAMES - 1);
                  w_expl_nxt[i]  = 1'b1;
               end else begin
                  w_timer_nxt[i] = r_timer[i] - TW'(1);
               end
            end
            S_BLAST: begin
               if (r_timer[i] == '0) w_state_nxt[i] = S_IDLE;
               else                  w_timer_nxt[i] = r_timer[i] - TW'(1);
            end
            default: w_state_nxt[i] = S_IDLE;
         endcase
      end
   end

   // Slot outputs decoded from registered state
   always_comb begin
      slot_fuse  = '0;
      slot_blast = '0;
      bomb_x     = '0;
      bomb_y     = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_fuse[i]     = (r_state[i] == S_FUSE);
         slot_blast[i]    = (r_state[i] == S_BLAST);
         bomb_x[10*i +: 10] = r_bx[i];
         bomb_y[10*i +: 10] = r_by[i];
      end
      slot_owner = r_owner;
      explode    = r_explode;
      p1_ack     = r_p1_ack;
      p2_ack     = r_p2_ack;
   end

   // Request edges, pending flags, round-robin pointer, acks and slot payload
   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         r_p1_prev <= 1'b0;
         r_p2_prev <= 1'b0;
         r_p1_pend <= 1'b0;
         r_p2_pend <= 1'b0;
         r_rr_p2   <= 1'b0;
         r_p1_ack  <= 1'b0;
         r_p2_ack  <= 1'b0;
         r_explode <= '0;
         r_owner   <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_timer[i] <= '0;
            r_bx[i]    <= '0;
            r_by[i]    <= '0;
         end
      end else begin
         r_p1_prev <= p1_drop;
         r_p2_prev <= p2_drop;
         // the selected player is resolved (granted or rejected); the other stays pending
         r_p1_pend <= w_req1 & ~(w_sel_any & ~w_sel_p2);
         r_p2_pend <= w_req2 & ~w_sel_p2;
         r_p1_ack  <= w_grant & ~w_sel_p2;
         r_p2_ack  <= w_grant & w_sel_p2;
         // pointer passes to the losing player whenever a contested grant is made
         if (w_grant && w_req1 && w_req2) r_rr_p2 <= ~w_sel_p2;
         r_explode <= w_expl_nxt;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            r_timer[i] <= w_timer_nxt[i];
            if (w_grant && w_free_idx == SW'(i)) begin
               r_owner[i] <= w_sel_p2;
               r_bx[i]    <= w_bx;
               r_by[i]    <= w_by;
            end
         end
      end
   end

endmodule
